// File: rtl/step_pulse_gen_pkg.sv
// Shared state encoding and sizing helpers for the manual step pulse path.
// Also consumed by the 7-segment display block.
package step_pulse_gen_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ESPERA = 2'd1,
    REPETE = 2'd2,
    LIVRE  = 2'd3
  } estado_e;

  // Interval timer width: enough bits for the longest reload value.
  function automatic int timer_w(
    input int hold_c,
    input int rep_c,
    input int free_c
  );
    int m;
    m = hold_c;
    if (rep_c > m) m = rep_c;
    if (free_c > m) m = free_c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/step_pulse_gen_interval_timer.sv
// Loadable down-counter shared by the hold, repeat and free-run intervals.
// Counts down to zero and parks there until reloaded.
module interval_timer
  import step_pulse_gen_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carga,
  input  logic [W-1:0] valor,
  output logic         zero
);

  logic [W-1:0] cont_q;
  logic [W-1:0] cont_d;

  // Reload wins over counting; stop at zero.
  always_comb begin
    cont_d = cont_q;
    if (carga) begin
      cont_d = valor;
    end else if (cont_q != '0) begin
      cont_d = cont_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign zero = (cont_q == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// Manual-step pulse generator: press pulse, auto-repeat, free-run and step count.
// Drives the core clock-enable with single-cycle pulses.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int FREE_CYCLES   = 1_000_000,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             botao_db,
  input  logic             modo_livre,
  output logic             passo,
  output logic             repetindo,
  output logic [CNT_W-1:0] contagem
);

  localparam int TW = timer_w(HOLD_CYCLES, REPEAT_CYCLES, FREE_CYCLES);

  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LD  = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] FREE_LD = TW'(FREE_CYCLES - 1);

  estado_e          state_q;
  estado_e          state_d;
  logic             botao_ant_q;
  logic             passo_q;
  logic             rep_q;
  logic             rep_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             borda;
  logic             pulso;
  logic             carga;
  logic [TW-1:0]    valor;
  logic             zero;

  interval_timer #(
    .W(TW)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .carga (carga),
    .valor (valor),
    .zero  (zero)
  );

  assign borda = botao_db & ~botao_ant_q;

  // Next state, timer reload and pulse request; free-run overrides the button.
  always_comb begin
    state_d = state_q;
    pulso   = 1'b0;
    carga   = 1'b0;
    valor   = '0;
    if (modo_livre) begin
      if (state_q != LIVRE) begin
        state_d = LIVRE;
        carga   = 1'b1;
        valor   = FREE_LD;
      end else if (zero) begin
        pulso = 1'b1;
        carga = 1'b1;
        valor = FREE_LD;
      end
    end else begin
      unique case (state_q)
        OCIOSO: begin
          if (borda) begin
            pulso   = 1'b1;
            carga   = 1'b1;
            valor   = HOLD_LD;
            state_d = ESPERA;
          end
        end
        ESPERA: begin
          if (!botao_db) begin
            state_d = OCIOSO;
          end else if (zero) begin
            pulso   = 1'b1;
            carga   = 1'b1;
            valor   = REP_LD;
            state_d = REPETE;
          end
        end
        REPETE: begin
          if (!botao_db) begin
            state_d = OCIOSO;
          end else if (zero) begin
            pulso = 1'b1;
            carga = 1'b1;
            valor = REP_LD;
          end
        end
        LIVRE: begin
          state_d = OCIOSO;
        end
      endcase
    end
  end

  // Registered output views of the next state and step count.
  always_comb begin
    rep_d = (state_d == REPETE) || (state_d == LIVRE);
    cnt_d = cnt_q + CNT_W'(pulso);
  end

  // State, edge history and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= OCIOSO;
      botao_ant_q <= 1'b1;
      passo_q     <= 1'b0;
      rep_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      botao_ant_q <= botao_db;
      passo_q     <= pulso;
      rep_q       <= rep_d;
      cnt_q       <= cnt_d;
    end
  end

  assign passo     = passo_q;
  assign repetindo = rep_q;
  assign contagem  = cnt_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen with short intervals.
// Expected pulses are queued by the stimulus and matched by a monitor.
module tb_step_pulse_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       botao;
  logic       modo;
  logic       passo;
  logic       rep;
  logic [3:0] contagem;

  int         cyc = 0;
  int         total = 0;
  int         passed = 0;
  logic [3:0] cnt_m = 4'd0;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  step_pulse_gen #(
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .FREE_CYCLES   (3),
    .CNT_W         (4)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .botao_db   (botao),
    .modo_livre (modo),
    .passo      (passo),
    .repetindo  (rep),
    .contagem   (contagem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int off);
    exp_t e;
    cnt_m = cnt_m + 4'd1;
    e.cyc = cyc + off;
    e.cnt = cnt_m;
    exp_q.push_back(e);
  endtask

  task automatic check(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d", n, got, exp);
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
    check(n, exp_q.size(), 0);
  endtask

  // Monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (passo === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse cyc=%0d cnt=%0d exp=none",
                 cyc, contagem);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc == cyc && e.cnt == contagem) passed++;
        else $display("FAIL pulse cyc=%0d cnt=%0d exp cyc=%0d cnt=%0d",
                      cyc, contagem, e.cyc, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    botao = 1'b0;
    modo  = 1'b0;
    tick(3);
    check("rst_passo", passo, 0);
    check("rst_rep", rep, 0);
    check("rst_cnt", contagem, 0);
    reset = 1'b0;
    tick(3);

    // single press
    botao = 1'b1;
    push(1);
    tick(5);
    botao = 1'b0;
    tick(3);
    drain("single_drain");
    check("single_cnt", contagem, 1);
    check("single_rep", rep, 0);

    // hold: press pulse then repeats at +8, +12, +16, +20
    botao = 1'b1;
    push(1);
    push(9);
    push(13);
    push(17);
    push(21);
    tick(8);
    check("hold_rep_wait", rep, 0);
    tick(1);
    check("hold_rep_on", rep, 1);
    tick(12);
    botao = 1'b0;
    tick(1);
    check("hold_rep_off", rep, 0);
    tick(2);
    drain("hold_drain");
    check("hold_cnt", contagem, 6);

    // release on the cycle the hold timer expires
    botao = 1'b1;
    push(1);
    tick(8);
    botao = 1'b0;
    tick(6);
    drain("expiry_drain");
    check("expiry_cnt", contagem, 7);
    check("expiry_rep", rep, 0);

    // free-run with the button toggling
    modo = 1'b1;
    push(4);
    push(7);
    push(10);
    for (int i = 0; i < 10; i++) begin
      botao = (i % 2 == 1);
      if (i == 2) check("free_rep", rep, 1);
      tick(1);
    end
    modo = 1'b0;
    tick(1);
    check("free_exit_rep", rep, 0);
    tick(5);
    botao = 1'b0;
    tick(2);
    drain("free_drain");
    check("free_cnt", contagem, 10);

    // reset one cycle before a repeat is due
    botao = 1'b1;
    push(1);
    push(9);
    push(13);
    tick(16);
    reset = 1'b1;
    tick(1);
    check("mid_rst_passo", passo, 0);
    check("mid_rst_cnt", contagem, 0);
    check("mid_rst_rep", rep, 0);
    cnt_m = 4'd0;
    botao = 1'b0;
    reset = 1'b0;
    tick(3);
    drain("mid_rst_drain");

    // button held across reset gives no pulse
    botao = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
    check("held_rst_cnt", contagem, 0);
    botao = 1'b0;
    tick(2);

    // 17 presses wrap the 4-bit count to 1
    for (int i = 0; i < 17; i++) begin
      botao = 1'b1;
      push(1);
      tick(2);
      botao = 1'b0;
      tick(2);
    end
    tick(3);
    drain("wrap_drain");
    check("wrap_cnt", contagem, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
